// File: rtl/ldc_pkg.sv
// Shared types and constants for the LDC trig unit; LDC_SAT_EN selects clamping arithmetic.
// No timing of its own: states, coefficient generator and term limits only.
package ldc_pkg;

`ifdef LDC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam int MAX_TERMS = 8;
  localparam int DEF_FRAC  = 11;
  localparam int ONE       = 1 << DEF_FRAC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR,
    S_ACC,
    S_COEF,
    S_POW,
    S_SCALE
  } state_t;

  // Ratio between successive Taylor terms, excluding the x^2 factor, rounded to nearest.
  function automatic int ldc_coef(input int frac, input int mode, input int k);
    int d;
    if (k < 1 || k >= MAX_TERMS) return 0;
    d = (mode == 0) ? (2 * k - 1) * (2 * k) : (2 * k) * (2 * k + 1);
    return -int'(((longint'(1) << frac) + longint'(d / 2)) / longint'(d));
  endfunction

endpackage

// File: rtl/ldc_fx_mult.sv
// Combinational sign-magnitude fixed-point multiply, truncating toward zero; clamps when LDC_SAT_EN.
// Zero latency, no handshake; sat flags a clamped result.
module ldc_fx_mult
  import ldc_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 11
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p,
  output logic                sat
);

  localparam logic [2*W-1:0] POS_LIM = (2*W)'((longint'(1) << (W - 1)) - 1);
  localparam logic [2*W-1:0] NEG_LIM = (2*W)'(longint'(1) << (W - 1));

  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] mag;
  logic           neg;

  always_comb begin
    p     = '0;
    sat   = 1'b0;
    mag_a = a[W-1] ? (~a + 1'b1) : a;
    mag_b = b[W-1] ? (~b + 1'b1) : b;
    prod  = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
    mag   = prod >> FRAC;
    neg   = a[W-1] ^ b[W-1];
    if (SAT_EN && !neg && (mag > POS_LIM)) begin
      p   = {1'b0, {(W-1){1'b1}}};
      sat = 1'b1;
    end else if (SAT_EN && neg && (mag > NEG_LIM)) begin
      p   = {1'b1, {(W-1){1'b0}}};
      sat = 1'b1;
    end else begin
      p = neg ? -mag[W-1:0] : mag[W-1:0];
    end
  end

endmodule

// File: rtl/ldc_trig_unit.sv
// Iterative Taylor-series v*cos(x) / v*sin(x); LDC_SAT_EN enables clamping and the sat flag.
// done pulses 3*TERMS cycles after launch; start is ignored while busy.
module ldc_trig_unit
  import ldc_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = DEF_FRAC,
  parameter int TERMS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] v,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] distance,
  output logic                sat
);

  localparam int KW = $clog2(MAX_TERMS);
  localparam logic [KW-1:0] K_LAST = KW'(TERMS - 1);
  // 1.0 rescaled from the default fraction width to FRAC.
  localparam logic signed [W-1:0] ONE_Q = W'((longint'(ONE) << FRAC) >> DEF_FRAC);
  localparam logic signed [W-1:0] MAX_Q = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_Q = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] coef_tab [2][MAX_TERMS];

  for (genvar m = 0; m < 2; m++) begin : g_mode
    for (genvar k = 0; k < MAX_TERMS; k++) begin : g_term
      localparam int C = ldc_coef(FRAC, m, k);
      assign coef_tab[m][k] = W'(C);
    end
  end

  state_t              state_q, state_d;
  logic signed [W-1:0] x_q, x_d, v_q, v_d, x2_q, x2_d;
  logic signed [W-1:0] term_q, term_d, acc_q, acc_d, dist_q, dist_d;
  logic [KW-1:0]       k_q, k_d, k_nxt;
  logic                mode_q, mode_d, done_q, done_d, sat_q, sat_d;

  logic signed [W-1:0] mul_a, mul_b, mul_p;
  logic                mul_sat;
  logic signed [W:0]   sum_wide;
  logic signed [W-1:0] sum_val;
  logic                sum_sat;

  ldc_fx_mult #(.W(W), .FRAC(FRAC)) u_mult (
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p),
    .sat (mul_sat)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    v_d      = v_q;
    mode_d   = mode_q;
    x2_d     = x2_q;
    term_d   = term_q;
    acc_d    = acc_q;
    k_d      = k_q;
    dist_d   = dist_q;
    sat_d    = sat_q;
    done_d   = 1'b0;
    mul_a    = '0;
    mul_b    = '0;
    k_nxt    = k_q + 1'b1;
    sum_wide = {acc_q[W-1], acc_q} + {term_q[W-1], term_q};
    sum_sat  = 1'b0;
    sum_val  = sum_wide[W-1:0];
    if (SAT_EN && (sum_wide[W] != sum_wide[W-1])) begin
      sum_val = sum_wide[W] ? MIN_Q : MAX_Q;
      sum_sat = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x;
          v_d     = v;
          mode_d  = mode;
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        mul_a   = x_q;
        mul_b   = x_q;
        x2_d    = mul_p;
        term_d  = mode_q ? x_q : ONE_Q;
        acc_d   = '0;
        k_d     = '0;
        sat_d   = mul_sat;
        state_d = S_ACC;
      end
      S_ACC: begin
        acc_d   = sum_val;
        sat_d   = sat_q | sum_sat;
        state_d = (k_q == K_LAST) ? S_SCALE : S_COEF;
      end
      S_COEF: begin
        mul_a   = term_q;
        mul_b   = coef_tab[mode_q][k_nxt];
        term_d  = mul_p;
        sat_d   = sat_q | mul_sat;
        state_d = S_POW;
      end
      S_POW: begin
        mul_a   = term_q;
        mul_b   = x2_q;
        term_d  = mul_p;
        k_d     = k_nxt;
        sat_d   = sat_q | mul_sat;
        state_d = S_ACC;
      end
      S_SCALE: begin
        mul_a   = v_q;
        mul_b   = acc_q;
        dist_d  = mul_p;
        sat_d   = sat_q | mul_sat;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      v_q     <= '0;
      mode_q  <= 1'b0;
      x2_q    <= '0;
      term_q  <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      dist_q  <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      v_q     <= v_d;
      mode_q  <= mode_d;
      x2_q    <= x2_d;
      term_q  <= term_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      dist_q  <= dist_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign distance = dist_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_ldc_trig_unit.sv
// Directed bench for ldc_trig_unit: hand-computed results, latency, handshake, reset and overflow.
// Expectations follow the LDC_SAT_EN setting of the build.
module tb_ldc_trig_unit;

  logic               clk;
  logic               rst;
  logic               start;
  logic               mode;
  logic signed [15:0] x;
  logic signed [15:0] v;
  logic               busy;
  logic               done;
  logic signed [15:0] distance;
  logic               sat;

  int errors;
  int checks;
  int lat;
  int seen;

`ifdef LDC_SAT_EN
  localparam int EXP_X2_OVF  = 32767;
  localparam int EXP_SAT_OVF = 1;
`else
  localparam int EXP_X2_OVF  = -32768;
  localparam int EXP_SAT_OVF = 0;
`endif

  ldc_trig_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .x        (x),
    .v        (v),
    .busy     (busy),
    .done     (done),
    .distance (distance),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic m, input int xi, input int vi);
    mode  = m;
    x     = 16'(xi);
    v     = 16'(vi);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns the number of rising edges until done is seen, or -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    x      = '0;
    v      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_distance", distance, 0);
    chk("reset_sat", sat, 0);
    chk("reset_x2", dut.x2_q, 0);

    // cos(0) * 2893
    launch(1'b0, 0, 2893);
    chk("cos0_busy_after_launch", busy, 1);
    wait_done(lat);
    chk("cos0_latency", lat, 24);
    chk("cos0_busy_in_done", busy, 0);
    chk("cos0_distance", distance, 2893);
    chk("cos0_sat", sat, 0);
    @(posedge clk);
    #1;
    chk("cos0_done_one_cycle", done, 0);
    chk("cos0_distance_hold", distance, 2893);

    launch(1'b1, 0, 2048);
    wait_done(lat);
    chk("sin0_latency", lat, 24);
    chk("sin0_distance", distance, 0);

    launch(1'b1, 3217, 2048);
    wait_done(lat);
    chk("sin_pi2_distance", distance, 2051);

    launch(1'b0, 2145, 10240);
    wait_done(lat);
    chk("cos_pi3_distance", distance, 5115);

    launch(1'b1, -2145, 2048);
    wait_done(lat);
    chk("sin_neg_pi3_distance", distance, -1774);

    // start held high across three operations
    mode  = 1'b0;
    x     = 16'sd0;
    v     = 16'sd2893;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat);
    chk("b2b_first_latency", lat, 24);
    chk("b2b_first_distance", distance, 2893);
    mode = 1'b1;
    x    = 16'sd3217;
    v    = 16'sd2048;
    wait_done(lat);
    chk("b2b_second_gap", lat, 25);
    chk("b2b_second_distance", distance, 2051);
    mode = 1'b0;
    x    = 16'sd2145;
    v    = 16'sd10240;
    wait_done(lat);
    chk("b2b_third_gap", lat, 25);
    chk("b2b_third_distance", distance, 5115);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_stops", busy, 0);

    // start pulse with new inputs in the middle of an operation
    launch(1'b1, 3217, 2048);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    mode  = 1'b0;
    x     = 16'sd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    chk("midstart_latency", lat, 18);
    chk("midstart_distance", distance, 2051);
    @(posedge clk);
    #1;
    chk("midstart_no_relaunch", busy, 0);

    // reset in cycle 10 of an operation, previous distance nonzero
    launch(1'b1, -2145, 2048);
    wait_done(lat);
    chk("pre_abort_distance", distance, -1774);
    launch(1'b0, 2145, 10240);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_distance", distance, 0);
    chk("abort_sat", sat, 0);
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    launch(1'b1, -2145, 2048);
    wait_done(lat);
    chk("after_abort_latency", lat, 24);
    chk("after_abort_distance", distance, -1774);

    // reset and start on the same edge
    mode  = 1'b0;
    x     = 16'sd0;
    v     = 16'sd2893;
    start = 1'b1;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_beats_start_busy", busy, 0);
    chk("rst_beats_start_distance", distance, 0);

    // x = 4.0: x*x overflows Q5.11
    launch(1'b0, 8192, 2048);
    @(posedge clk);
    #1;
    chk("ovf_x2", dut.x2_q, EXP_X2_OVF);
    wait_done(lat);
    chk("ovf_latency", lat, 23);
    chk("ovf_sat", sat, EXP_SAT_OVF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
